// File: rtl/systolic_skew_stream.sv
// Per-lane skew/deskew delay lines with a drain FSM that flushes the diagonal and pulses done.
// Define SKEW_DESKEW_MODE_EN to honour the mode input (deskew taps); otherwise every block is skewed.
module systolic_skew_stream #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 32,
    parameter int STEP      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [DATAWIDTH-1:0] in_data   [N_SIZE],
    output logic [DATAWIDTH-1:0] out_data  [N_SIZE],
    output logic [N_SIZE-1:0]    out_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int D_MAX = (N_SIZE - 1) * STEP;
    localparam int CNT_W = (D_MAX > 1) ? $clog2(D_MAX + 1) : 1;
    localparam bit NO_DRAIN = (D_MAX == 0);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             adv;
    logic             st0_vld;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_STREAM);
    assign accept   = in_valid && in_ready;
    assign adv      = accept || (state_q == S_DRAIN);
    assign st0_vld  = accept;
    assign busy     = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = NO_DRAIN ? S_DONE : S_DRAIN;
                        cnt_d   = CNT_W'(D_MAX);
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_DRAIN: begin
                // The count-1 cycle carries the final advance of the diagonal.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

`ifdef SKEW_DESKEW_MODE_EN
    logic mode_q, mode_d, mode_eff;

    // The opening beat of a block already uses the mode presented with it.
    assign mode_eff = (state_q == S_IDLE) ? mode : mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (clr) begin
            mode_d = 1'b0;
        end else if ((state_q == S_IDLE) && accept) begin
            mode_d = mode;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
`ifdef SKEW_DESKEW_MODE_EN
        localparam int D_SK  = i * STEP;
        localparam int D_DK  = (N_SIZE - 1 - i) * STEP;
        localparam int DEPTH = (D_SK > D_DK) ? D_SK : D_DK;
`else
        localparam int DEPTH = i * STEP;
`endif
        logic [DATAWIDTH-1:0] st0_data;
        logic [DATAWIDTH-1:0] tap_data;
        logic                 tap_vld;

        assign st0_data = accept ? in_data[i] : '0;

        if (DEPTH == 0) begin : g_pass
            assign tap_data = st0_data;
            assign tap_vld  = st0_vld;
        end else begin : g_pipe
            logic [DATAWIDTH-1:0] data_q [DEPTH];
            logic [DEPTH-1:0]     vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
                    vld_q <= '0;
                end else if (clr) begin
                    for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
                    vld_q <= '0;
                end else if (adv) begin
                    data_q[0] <= st0_data;
                    vld_q[0]  <= st0_vld;
                    for (int s = 1; s < DEPTH; s++) begin
                        data_q[s] <= data_q[s-1];
                        vld_q[s]  <= vld_q[s-1];
                    end
                end
            end

`ifdef SKEW_DESKEW_MODE_EN
            logic [DATAWIDTH-1:0] sk_data, dk_data;
            logic                 sk_vld, dk_vld;

            if (D_SK == 0) begin : g_sk0
                assign sk_data = st0_data;
                assign sk_vld  = st0_vld;
            end else begin : g_skn
                assign sk_data = data_q[D_SK-1];
                assign sk_vld  = vld_q[D_SK-1];
            end

            if (D_DK == 0) begin : g_dk0
                assign dk_data = st0_data;
                assign dk_vld  = st0_vld;
            end else begin : g_dkn
                assign dk_data = data_q[D_DK-1];
                assign dk_vld  = vld_q[D_DK-1];
            end

            assign tap_data = mode_eff ? dk_data : sk_data;
            assign tap_vld  = mode_eff ? dk_vld  : sk_vld;
`else
            assign tap_data = data_q[DEPTH-1];
            assign tap_vld  = vld_q[DEPTH-1];
`endif
        end

        assign out_valid[i] = adv && tap_vld;
        assign out_data[i]  = out_valid[i] ? tap_data : '0;
    end

endmodule
